// File: rtl/reg_dump_reader_pkg.sv
// rtl/reg_dump_reader_pkg.sv - shared widths and FSM state encoding for the register dump reader
package reg_dump_reader_pkg;

    localparam int DUMP_DATA_W = 32;
    localparam int DUMP_ADDR_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SET  = 3'd1,
        ST_CAPT = 3'd2,
        ST_SEND = 3'd3,
        ST_FIN  = 3'd4
    } dump_state_e;

endpackage

// File: rtl/reg_dump_ctr.sv
// rtl/reg_dump_ctr.sv - register index counter with load, saturating increment and last flag
module reg_dump_ctr #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] idx_o,
    output logic              is_last_o
);

    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] idx_d;

    assign idx_o     = idx_q;
    assign is_last_o = (idx_q == {ADDR_W{1'b1}});

    // Next index: clear wins over load, increment never wraps past the last address
    always_comb begin
        idx_d = idx_q;
        if (clr_i) begin
            idx_d = '0;
        end else if (load_i) begin
            idx_d = load_val_i;
        end else if (inc_i && !is_last_o) begin
            idx_d = idx_q + ADDR_W'(1);
        end
    end

    // Index register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/reg_dump_reader.sv
// rtl/reg_dump_reader.sv - walks the register file through a spare read port and streams (addr,data) words
module reg_dump_reader
    import reg_dump_reader_pkg::*;
#(
    parameter int DATA_W    = DUMP_DATA_W,
    parameter int ADDR_W    = DUMP_ADDR_W,
    parameter int SKIP_ZERO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    // r0 is hard-wired zero on some cores, so the walk can begin at 1
    localparam logic [ADDR_W-1:0] START_IDX = (SKIP_ZERO != 0) ? ADDR_W'(1) : '0;

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              ctr_clr, ctr_load, ctr_inc;
    logic [ADDR_W-1:0] idx;
    logic              idx_is_last;
    logic              handshake;

    assign handshake = out_valid_q && out_ready;

    reg_dump_ctr #(
        .ADDR_W (ADDR_W)
    ) u_ctr (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (ctr_clr),
        .load_i     (ctr_load),
        .load_val_i (START_IDX),
        .inc_i      (ctr_inc),
        .idx_o      (idx),
        .is_last_o  (idx_is_last)
    );

    // Sequencing: abort overrides everything; rd_addr is updated together with idx so
    // the combinational read has the whole SET cycle to settle before CAPT samples it
    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        ctr_clr     = 1'b0;
        ctr_load    = 1'b0;
        ctr_inc     = 1'b0;
        if (abort) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            rd_addr_d   = '0;
            ctr_clr     = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        ctr_load  = 1'b1;
                        rd_addr_d = START_IDX;
                        busy_d    = 1'b1;
                        state_d   = ST_SET;
                    end
                end
                ST_SET: begin
                    state_d = ST_CAPT;
                end
                ST_CAPT: begin
                    out_data_d  = rd_data;
                    out_addr_d  = idx;
                    out_valid_d = 1'b1;
                    state_d     = ST_SEND;
                end
                ST_SEND: begin
                    if (handshake) begin
                        out_valid_d = 1'b0;
                        if (idx_is_last) begin
                            done_d  = 1'b1;
                            state_d = ST_FIN;
                        end else begin
                            ctr_inc   = 1'b1;
                            rd_addr_d = idx + ADDR_W'(1);
                            state_d   = ST_SET;
                        end
                    end
                end
                ST_FIN: begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rd_addr_q   <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign rd_addr   = rd_addr_q;
    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// tb/tb_reg_dump_reader.sv - scoreboard bench for reg_dump_reader
module tb_reg_dump_reader;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NREG = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start0 = 1'b0;
    logic          start1 = 1'b0;
    logic          abort = 1'b0;
    logic          out_ready = 1'b1;
    logic [AW-1:0] rd_addr0, rd_addr1, out_addr0, out_addr1;
    logic [DW-1:0] rd_data0, rd_data1, out_data0, out_data1;
    logic          out_valid0, out_valid1, busy0, busy1, done0, done1;
    logic [DW-1:0] regs [NREG];

    int total = 0;
    int bad   = 0;
    int exp_a [$];
    int exp_d [$];

    assign rd_data0 = regs[rd_addr0];
    assign rd_data1 = regs[rd_addr1];

    always #5 clk = ~clk;

    reg_dump_reader #(.DATA_W(DW), .ADDR_W(AW), .SKIP_ZERO(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort),
        .rd_addr(rd_addr0), .rd_data(rd_data0),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_addr(out_addr0), .out_data(out_data0),
        .busy(busy0), .done(done0)
    );

    reg_dump_reader #(.DATA_W(DW), .ADDR_W(AW), .SKIP_ZERO(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort),
        .rd_addr(rd_addr1), .rd_data(rd_data1),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_addr(out_addr1), .out_data(out_data1),
        .busy(busy1), .done(done1)
    );

    task automatic pulse_start(input bit sel1);
        if (sel1) start1 = 1'b1;
        else      start0 = 1'b1;
    endtask

    // Drives one dump, scoreboarding every accepted word. Optional: hold out_ready low
    // 5 cycles at hold_addr, pulse start at restart_addr and in FIN, or return early
    // (optionally raising abort) once stop_addr is presented.
    task automatic dump_walk(input bit sel1, input int hold_addr, input int restart_addr,
                             input int stop_addr, input bit stop_abort,
                             output int words, output int busy_cyc, output int done_cnt,
                             output int last_addr);
        int held, post, a, d, ea, ed;
        bit restarted, v, bz, dn;
        words = 0; busy_cyc = 0; done_cnt = 0; last_addr = -1;
        held = 0; post = 0; restarted = 1'b0;
        exp_a.delete();
        exp_d.delete();
        for (int i = (sel1 ? 1 : 0); i < NREG; i++) begin
            exp_a.push_back(i);
            exp_d.push_back(i * 4);
        end
        @(negedge clk);
        out_ready = 1'b1;
        pulse_start(sel1);
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            start0 = 1'b0; start1 = 1'b0; out_ready = 1'b1;
            v  = sel1 ? out_valid1 : out_valid0;
            a  = int'(sel1 ? out_addr1 : out_addr0);
            d  = int'(sel1 ? out_data1 : out_data0);
            bz = sel1 ? busy1 : busy0;
            dn = sel1 ? done1 : done0;
            if (bz) busy_cyc++;
            if (dn) begin
                done_cnt++;
                if (restart_addr >= 0) pulse_start(sel1);
            end
            if (done_cnt > 0) post++;
            if (v && a == stop_addr) begin
                if (stop_abort) abort = 1'b1;
                return;
            end
            if ((held > 0 && held < 5) || (held == 0 && v && a == hold_addr)) begin
                out_ready = 1'b0;
                total++;
                if (v !== 1'b1 || a != hold_addr || d != hold_addr * 4) begin
                    bad++;
                    $display("FAIL hold_stable cycle=%0d got v=%0b addr=%0d data=%0d want v=1 addr=%0d data=%0d",
                             held, v, a, d, hold_addr, hold_addr * 4);
                end
                held++;
            end
            if (v && a == restart_addr && !restarted) begin
                pulse_start(sel1);
                restarted = 1'b1;
            end
            if (v && out_ready) begin
                words++;
                last_addr = a;
                total++;
                if (exp_a.size() == 0) begin
                    bad++;
                    $display("FAIL word_unexpected got addr=%0d data=%0d want none", a, d);
                end else begin
                    ea = exp_a.pop_front();
                    ed = exp_d.pop_front();
                    if (a != ea || d != ed) begin
                        bad++;
                        $display("FAIL word got addr=%0d data=%0d want addr=%0d data=%0d", a, d, ea, ed);
                    end
                end
            end
            if (post >= 4) return;
        end
        total++;
        bad++;
        $display("FAIL walk_timeout got words=%0d want completion", words);
    endtask

    task automatic check_int(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        total++;
        if ({out_valid0, busy0, done0, out_addr0, out_data0, rd_addr0} !== '0) begin
            bad++;
            $display("FAIL reset_dut0 got v=%0b b=%0b d=%0b a=%0d data=%0d ra=%0d want all 0",
                     out_valid0, busy0, done0, out_addr0, out_data0, rd_addr0);
        end
        total++;
        if ({out_valid1, busy1, done1, out_addr1, out_data1, rd_addr1} !== '0) begin
            bad++;
            $display("FAIL reset_dut1 got v=%0b b=%0b d=%0b a=%0d data=%0d ra=%0d want all 0",
                     out_valid1, busy1, done1, out_addr1, out_data1, rd_addr1);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (busy0 !== 1'b0 || out_valid0 !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle got busy=%0b valid=%0b want 0 0", busy0, out_valid0);
        end
    endtask

    task automatic test_full_dump();
        int w, b, dc, la;
        dump_walk(1'b0, -1, -1, -1, 1'b0, w, b, dc, la);
        check_int("full_words", w, 32);
        check_int("full_busy_cycles", b, 97);
        check_int("full_done_pulses", dc, 1);
        check_int("full_last_addr", la, 31);
        check_int("full_queue_left", exp_a.size(), 0);
    endtask

    task automatic test_skip_zero();
        int w, b, dc, la;
        dump_walk(1'b1, -1, -1, -1, 1'b0, w, b, dc, la);
        check_int("skip_words", w, 31);
        check_int("skip_busy_cycles", b, 94);
        check_int("skip_done_pulses", dc, 1);
        check_int("skip_last_addr", la, 31);
    endtask

    task automatic test_backpressure();
        int w, b, dc, la;
        dump_walk(1'b0, 7, -1, -1, 1'b0, w, b, dc, la);
        check_int("bp_words", w, 32);
        check_int("bp_busy_cycles", b, 102);
        check_int("bp_queue_left", exp_a.size(), 0);
    endtask

    task automatic test_abort();
        int w, b, dc, la;
        dump_walk(1'b0, -1, -1, 12, 1'b1, w, b, dc, la);
        check_int("abort_words_before", w, 12);
        @(negedge clk);
        abort = 1'b0;
        total++;
        if (out_valid0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle got v=%0b busy=%0b done=%0b want 0 0 0", out_valid0, busy0, done0);
        end
        repeat (3) @(negedge clk);
        check_int("abort_no_done", int'(done0), 0);
        dump_walk(1'b0, -1, -1, -1, 1'b0, w, b, dc, la);
        check_int("abort_redump_words", w, 32);
        check_int("abort_redump_done", dc, 1);
    endtask

    task automatic test_start_while_busy();
        int w, b, dc, la;
        dump_walk(1'b0, -1, 3, -1, 1'b0, w, b, dc, la);
        check_int("restart_words", w, 32);
        check_int("restart_busy_cycles", b, 97);
        check_int("restart_done_pulses", dc, 1);
    endtask

    task automatic test_rst_mid();
        int w, b, dc, la, dones;
        dump_walk(1'b0, -1, -1, 20, 1'b0, w, b, dc, la);
        check_int("rst_words_before", w, 20);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({out_valid0, busy0, done0, out_addr0, out_data0, rd_addr0} !== '0) begin
            bad++;
            $display("FAIL rst_mid_async got v=%0b b=%0b d=%0b a=%0d data=%0d ra=%0d want all 0",
                     out_valid0, busy0, done0, out_addr0, out_data0, rd_addr0);
        end
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        b = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done0) dones++;
            if (busy0 || out_valid0) b++;
        end
        check_int("rst_mid_stays_idle", b, 0);
        check_int("rst_mid_no_done", dones, 0);
        exp_a.delete();
        exp_d.delete();
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) regs[i] = DW'(i * 4);
        test_reset();
        test_full_dump();
        test_skip_zero();
        test_backpressure();
        test_abort();
        test_start_while_busy();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
